// File: rtl/gru_ctrl_pkg.sv
// Shared types and sizing helpers for the GRU sequence controller.
package gru_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } ctrl_state_t;

    // Counter width for a counter running over 0..n-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gru_sequence_controller_vec_serializer.sv
// Drains a captured hidden vector onto a scalar valid/ready stream, element 0 first.
module vec_serializer
    import gru_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int H_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic [H_SIZE-1:0][WIDTH-1:0]   vec,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    output logic                           out_last,
    output logic                           done
);

    localparam int unsigned IW = cnt_width(H_SIZE);
    localparam logic [IW-1:0] IDX_LAST = IW'(H_SIZE - 1);

    logic [IW-1:0] out_idx;

    // Element index advances on each accepted beat and wraps after the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_idx <= '0;
        end else if (active && out_ready) begin
            out_idx <= (out_idx == IDX_LAST) ? '0 : out_idx + 1'b1;
        end
    end

    assign out_valid = active;
    assign out_data  = vec[out_idx];
    assign out_last  = active && (out_idx == IDX_LAST);
    assign done      = active && out_ready && (out_idx == IDX_LAST);

endmodule

// File: rtl/gru_sequence_controller.sv
// Steps a GRU cell through SEQ_LEN time steps: gathers x_t, waits the cell
// latency, feeds h_t back as h_{t-1}, and finally streams out the hidden state.
module gru_sequence_controller
    import gru_ctrl_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NFRAC        = 12,
    parameter int X_SIZE       = 8,
    parameter int H_SIZE       = 8,
    parameter int SEQ_LEN      = 4,
    parameter int CELL_LATENCY = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [X_SIZE-1:0][WIDTH-1:0]   cell_x_t,
    output logic [H_SIZE-1:0][WIDTH-1:0]   cell_h_prev,
    input  logic [H_SIZE-1:0][WIDTH-1:0]   cell_h_t,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy
);

    if (NFRAC >= WIDTH || SEQ_LEN < 1 || CELL_LATENCY < 1) begin : g_param_check
        $error("gru_sequence_controller: illegal parameter combination");
    end

    localparam int unsigned EW = cnt_width(X_SIZE);
    localparam int unsigned LW = cnt_width(CELL_LATENCY);
    localparam int unsigned SW = cnt_width(SEQ_LEN);
    localparam logic [EW-1:0] ELEM_LAST = EW'(X_SIZE - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(CELL_LATENCY - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(SEQ_LEN - 1);

    ctrl_state_t state, state_nxt;

    logic [EW-1:0] elem_cnt;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] step_cnt;
    logic [X_SIZE-1:0][WIDTH-1:0] x_buf;
    logic [H_SIZE-1:0][WIDTH-1:0] h_reg;

    logic accept;
    logic capture;
    logic drain_done;

    assign cell_x_t    = x_buf;
    assign cell_h_prev = h_reg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-state strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (elem_cnt == ELEM_LAST)) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = (step_cnt == STEP_LAST) ? DRAIN : LOAD;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Counters and the x_t / h_{t-1} holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_cnt <= '0;
            lat_cnt  <= '0;
            step_cnt <= '0;
            x_buf    <= '0;
            h_reg    <= '0;
        end else begin
            if (accept) begin
                x_buf[elem_cnt] <= in_data;
                if (elem_cnt == ELEM_LAST) begin
                    elem_cnt <= '0;
                    lat_cnt  <= '0;
                end else begin
                    elem_cnt <= elem_cnt + 1'b1;
                end
            end
            if (state == COMPUTE) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (capture) begin
                h_reg    <= cell_h_t;
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
            end
            // A finished drain leaves zero state for the next sequence.
            if (drain_done) begin
                h_reg <= '0;
            end
        end
    end

    vec_serializer #(
        .WIDTH  (WIDTH),
        .H_SIZE (H_SIZE)
    ) u_vec_serializer (
        .clk       (clk),
        .reset     (reset),
        .active    (state == DRAIN),
        .vec       (h_reg),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_gru_sequence_controller.sv
// Self-checking bench for gru_sequence_controller with a stub h_t = h_prev + x cell.
module tb_gru_sequence_controller;

    localparam int W = 16;
    localparam int X = 8;
    localparam int H = 8;
    localparam int S = 4;
    localparam int L = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [W-1:0]           in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [X-1:0][W-1:0]    cell_x_t;
    logic [H-1:0][W-1:0]    cell_h_prev;
    logic [H-1:0][W-1:0]    cell_h_t;
    logic [W-1:0]           out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;

    always #5 clk = ~clk;

    gru_sequence_controller #(
        .WIDTH        (W),
        .NFRAC        (12),
        .X_SIZE       (X),
        .H_SIZE       (H),
        .SEQ_LEN      (S),
        .CELL_LATENCY (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cell_x_t    (cell_x_t),
        .cell_h_prev (cell_h_prev),
        .cell_h_t    (cell_h_t),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stub cell: the sum is only presented once its inputs have been stable
    // for L cycles; before that it drives a poison word.
    logic [X-1:0][W-1:0] seen_x = '0;
    logic [H-1:0][W-1:0] seen_h = '0;
    int stab = 0;
    always @(negedge clk) begin
        if (cell_x_t !== seen_x || cell_h_prev !== seen_h) begin
            seen_x = cell_x_t;
            seen_h = cell_h_prev;
            stab = 1;
        end else begin
            stab++;
        end
        for (int i = 0; i < H; i++)
            cell_h_t[i] = (stab >= L) ? cell_h_prev[i] + cell_x_t[i] : 16'hDEAD;
    end

    // Reference model: x per step, hidden state before each step, input stream.
    logic [W-1:0] xs [S][X];
    logic [W-1:0] hb [S+1][H];
    logic [W-1:0] exp_out [H];
    logic [W-1:0] inq [$];

    task automatic build_model();
        inq.delete();
        for (int i = 0; i < H; i++) hb[0][i] = '0;
        for (int s = 0; s < S; s++) begin
            for (int i = 0; i < H; i++) hb[s+1][i] = hb[s][i] + xs[s][i];
            for (int i = 0; i < X; i++) inq.push_back(xs[s][i]);
        end
    endtask

    task automatic run_seq(input int gap_pct, input int bp_mode, input int exp_lat, input string tag);
        int cyc = 0, first_acc = -1, first_ov = -1, n_acc = 0, s;
        int v_excl = 0, v_hold = 0, v_stall = 0, v_last = 0;
        logic stalled = 1'b0;
        logic [W-1:0] stall_data = '0;
        logic [W-1:0] got [$];
        while (got.size() < H && cyc < 3000) begin
            @(posedge clk); #1;
            in_valid = (inq.size() > 0) && ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? inq[0] : W'($urandom);
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            if (in_ready && (out_valid || busy)) v_excl++;
            if (stalled && (!out_valid || out_data !== stall_data)) v_stall++;
            if (busy && !out_valid) begin
                s = (n_acc >= X) ? n_acc / X - 1 : 0;
                for (int i = 0; i < X; i++) if (cell_x_t[i] !== xs[s][i]) v_hold++;
                for (int i = 0; i < H; i++) if (cell_h_prev[i] !== hb[s][i]) v_hold++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                void'(inq.pop_front());
                n_acc++;
            end
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (out_last !== (got.size() == H - 1)) v_last++;
                if (out_ready) got.push_back(out_data);
            end
            stalled = out_valid && !out_ready;
            stall_data = out_data;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " out_count"}, got.size(), H);
        for (int i = 0; i < H && i < got.size(); i++)
            check($sformatf("%s out[%0d]", tag, i), got[i], exp_out[i]);
        check({tag, " ready_valid_excl"}, v_excl, 0);
        check({tag, " cell_inputs_hold"}, v_hold, 0);
        check({tag, " stall_stable"}, v_stall, 0);
        check({tag, " out_last"}, v_last, 0);
        if (exp_lat >= 0) check({tag, " latency"}, first_ov - first_acc, exp_lat);
        @(posedge clk); #1;
        check({tag, " post_in_ready"}, in_ready, 1'b1);
        check({tag, " post_out_valid"}, out_valid, 1'b0);
        check({tag, " post_h_cleared"}, cell_h_prev, '0);
    endtask

    typedef struct {
        logic [W-1:0] fill;
        bit           ramp;
        int           gap_pct;
        int           bp;
        logic [W-1:0] exp0;
        logic [W-1:0] exp_inc;
        int           exp_lat;
    } row_t;

    row_t rows [5];

    task automatic set_x(input logic [W-1:0] fill, input bit ramp);
        for (int s = 0; s < S; s++)
            for (int i = 0; i < X; i++)
                xs[s][i] = ramp ? ((s == 0) ? W'(i + 1) : '0) : fill;
        build_model();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, c;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        rows[0] = '{16'h0100, 1'b0, 0,  0, 16'h0400, 16'h0000, S*(X+L)};
        rows[1] = '{16'h0000, 1'b1, 0,  0, 16'h0001, 16'h0001, S*(X+L)};
        rows[2] = '{16'h0100, 1'b0, 0,  1, 16'h0400, 16'h0000, S*(X+L)};
        rows[3] = '{16'h0100, 1'b0, 40, 0, 16'h0400, 16'h0000, -1};
        rows[4] = '{16'h0010, 1'b0, 0,  0, 16'h0040, 16'h0000, S*(X+L)};

        repeat (2) @(posedge clk); #1;
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_last", out_last, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst cell_x_t", cell_x_t, '0);
        check("rst cell_h_prev", cell_h_prev, '0);
        reset = 1'b0;

        for (int r = 0; r < 5; r++) begin
            set_x(rows[r].fill, rows[r].ramp);
            for (int i = 0; i < H; i++) exp_out[i] = rows[r].exp0 + W'(i) * rows[r].exp_inc;
            run_seq(rows[r].gap_pct, rows[r].bp, rows[r].exp_lat, $sformatf("row%0d", r));
        end

        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < S; s++)
                for (int i = 0; i < X; i++) xs[s][i] = W'($urandom);
            build_model();
            for (int i = 0; i < H; i++) exp_out[i] = hb[S][i];
            run_seq(int'($urandom_range(50)), 2, -1, $sformatf("rand%0d", r));
        end

        // Reset while step 2 is computing, then a clean sequence.
        set_x(16'h0123, 1'b0);
        n = 0; c = 0;
        while (n < 2 * X && c < 500) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = inq[0];
            @(negedge clk);
            if (in_ready) begin void'(inq.pop_front()); n++; end
            c++;
        end
        check("mid accepted", n, 2 * X);
        repeat (3) @(posedge clk);
        #3;
        check("mid busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid in_ready", in_ready, 1'b1);
        check("mid out_valid", out_valid, 1'b0);
        check("mid busy", busy, 1'b0);
        check("mid cell_h_prev", cell_h_prev, '0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        set_x(16'h0100, 1'b0);
        for (int i = 0; i < H; i++) exp_out[i] = 16'h0400;
        run_seq(0, 0, S*(X+L), "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gru_sequence_controller.md
Name: gru_sequence_controller

Overview:
Sequencer that drives a combinational/pipelined GRU cell across a time sequence of SEQ_LEN steps. It deserialises a scalar input stream into the x_t vector and presents x_t and h_{t-1} to the cell. After a fixed cell latency it captures h_t and feeds it back as the next h_{t-1}. After the final step it serialises the hidden state onto a valid/ready output stream. It sits between the sample-stream front end and the gru cell, and owns all recurrence state.

Parameters:
WIDTH, 16, data word width (signed fixed point)
NFRAC, 12, fractional bits (pass-through; no arithmetic performed here)
X_SIZE, 8, elements per input vector x_t
H_SIZE, 8, elements per hidden vector h_t
SEQ_LEN, 4, time steps per sequence (>=1)
CELL_LATENCY, 6, clock cycles from stable cell inputs to valid cell h_t (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_data  in  WIDTH  one x element per beat, element 0 first
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data
cell_x_t  out  WIDTH x X_SIZE  x_t vector to cell
cell_h_prev  out  WIDTH x H_SIZE  h_{t-1} vector to cell
cell_h_t  in  WIDTH x H_SIZE  h_t vector from cell
out_data  out  WIDTH  final hidden element, element 0 first
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  high with element H_SIZE-1
busy  out  1  high in COMPUTE or DRAIN

Behaviour:
- Reset (async, any state): state=LOAD, elem_cnt=0, lat_cnt=0, step_cnt=0, out_idx=0, x_buf=0, h_reg=0. Outputs then: in_ready=1, out_valid=0, out_last=0, busy=0, cell_x_t=0, cell_h_prev=0.
- cell_x_t=x_buf and cell_h_prev=h_reg are direct register outputs. They change only on input acceptance (LOAD), capture, or drain completion.
- LOAD:
  - in_ready=1. A beat is accepted on in_valid&in_ready; x_buf[elem_cnt]<=in_data, elem_cnt++.
  - When the beat with elem_cnt==X_SIZE-1 is accepted: elem_cnt<=0, lat_cnt<=0, go to COMPUTE.
- COMPUTE:
  - in_ready=0; in_valid is ignored and the data is not lost (the source holds it).
  - lat_cnt increments each cycle. The first COMPUTE cycle is the first cycle with the full x_buf stable.
  - In the cycle with lat_cnt==CELL_LATENCY-1: h_reg<=cell_h_t.
    - If step_cnt==SEQ_LEN-1: step_cnt<=0, go to DRAIN.
    - Else: step_cnt++, go to LOAD.
- DRAIN:
  - out_valid=1, out_data=h_reg[out_idx], out_last=(out_idx==H_SIZE-1). out_data is stable while out_ready=0.
  - On handshake, out_idx++.
  - On the last handshake: out_idx<=0, h_reg<=0, go to LOAD. The next sequence starts from zero state.
- Cycle count per step: X_SIZE accept cycles (with no stalls) + CELL_LATENCY. The first beat of the next step is accepted the cycle after capture.
- in_ready and out_valid are never both 1. A step cannot start while draining.
- SEQ_LEN=1: every COMPUTE goes directly to DRAIN. CELL_LATENCY=1: capture happens in the first COMPUTE cycle.
- Counter widths: $clog2 of the respective size, minimum 1 bit.
- No arithmetic on data; words are passed bit-exact.

Decomposition:
- Package gru_ctrl_pkg: state enum (LOAD, COMPUTE, DRAIN) and counter-width localparam functions.
- One natural sub-module, vec_serializer: the H_SIZE-to-scalar valid/ready drain (out_idx, out_last). It is instantiated once.

Test Plan:
Bench stub cell: h_t = h_prev + x elementwise (X_SIZE=H_SIZE=8), delayed exactly CELL_LATENCY, with outputs X-forced at other times.
1. Basic sequence: SEQ_LEN=4, all x elements 0x0100, in_valid always high, out_ready high -> 8 outputs of 0x0400, out_last only on the 8th. Exactly 4*(8+6) cycles from the first accept to the first out_valid.
2. Per-element ordering: single step, x={1..8} -> outputs 1,2,...,8 in order. cell_x_t[k]=k+1 holds throughout COMPUTE.
3. Backpressure: out_ready toggles 1 cycle on / 2 cycles off -> out_data stable while stalled, no element dropped or duplicated, and in_ready=0 for the whole drain.
4. Input gaps: in_valid randomly deasserted during LOAD -> same result as scenario 1. in_valid held high during COMPUTE -> no beat is accepted (in_ready=0).
5. Back-to-back sequences: second sequence with x=0x0010 -> outputs 0x0040, confirming h_reg was cleared after the first drain.
6. Reset mid-COMPUTE in step 2, then a full sequence of 0x0100 -> outputs 0x0400 (no stale state). Immediately after reset asserts: in_ready=1, out_valid=0, busy=0, cell_h_prev=0.
